// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one command byte to a PS/2 device. The host inhibits the bus, issues
// request-to-send, then shifts out data[0..7], odd parity and stop on the
// falling edges of the device clock. It then samples the device ACK and waits
// for the bus to go idle. Both pins are open-drain: an oe of 1 pulls the pin low.
//
// Ports:
//   clk, rst            system clock; asynchronous active-low reset
//   tx_data, tx_valid   command byte and request (accepted when tx_ready=1)
//   tx_ready            idle, a byte can be accepted
//   ps2_clk_in/data_in  raw pin levels (synchronized internally)
//   ps2_clk_oe/data_oe  1 = pull the pin low, 0 = release
//   done                one-cycle pulse at the end of every transfer
//   ack_err             last transfer saw no ACK from the device
//   timeout_err         last transfer was aborted by the watchdog
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 743,
    parameter int TIMEOUT_CYCLES = 148500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    // Phase counter covers both INHIBIT (INHIBIT_CYCLES) and RTS (8 cycles).
    localparam int CW = (INHIBIT_CYCLES > 8) ? $clog2(INHIBIT_CYCLES) : 3;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    state_t        state;
    state_t        state_d;

    logic          clk_meta;
    logic          clk_s;
    logic          clk_prev;
    logic          data_meta;
    logic          data_s;
    logic          clk_fall;

    logic [CW-1:0] phase_cnt;
    logic [TW-1:0] tcnt;
    logic [3:0]    bit_cnt;
    // {stop, parity, data[7:0]}; shifted right, bit 0 is the next bit to present
    logic [9:0]    frame;
    logic          data_oe_q;

    logic          watch;
    logic          timeout;
    logic          done_set;

    assign clk_fall = clk_prev & ~clk_s;

    // The watchdog only runs while the device owns the clock.
    assign watch    = (state == ST_SEND) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
    // Checked regardless of clk_fall so that a simultaneous edge loses to the timeout.
    assign timeout  = watch && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign done_set = watch && (state_d == ST_IDLE);

    assign tx_ready    = (state == ST_IDLE);
    assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_RTS);
    assign ps2_data_oe = (state == ST_RTS) || ((state == ST_SEND) && data_oe_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (phase_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                if (phase_cnt == CW'(7)) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (clk_fall && (bit_cnt == 4'd9)) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (clk_fall) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (timeout || (clk_s && data_s)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta    <= 1'b1;
            clk_s       <= 1'b1;
            clk_prev    <= 1'b1;
            data_meta   <= 1'b1;
            data_s      <= 1'b1;
            phase_cnt   <= '0;
            tcnt        <= '0;
            bit_cnt     <= '0;
            frame       <= '1;
            data_oe_q   <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_s     <= clk_meta;
            clk_prev  <= clk_s;
            data_meta <= ps2_data_in;
            data_s    <= data_meta;

            done <= done_set;

            // Held at zero outside the watched states, so it starts clean in SEND.
            if (watch && !clk_fall) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end

            if (timeout) begin
                timeout_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    phase_cnt <= '0;
                    if (tx_valid) begin
                        frame       <= {1'b1, ~^tx_data, tx_data};
                        ack_err     <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (state_d == ST_RTS) begin
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                ST_RTS: begin
                    phase_cnt <= phase_cnt + CW'(1);
                    bit_cnt   <= '0;
                    // Start bit keeps the data line low until the first device edge.
                    data_oe_q <= 1'b1;
                end
                ST_SEND: begin
                    if (clk_fall && !timeout) begin
                        data_oe_q <= ~frame[0];
                        frame     <= {1'b1, frame[9:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end
                end
                ST_ACK: begin
                    if (clk_fall && !timeout) begin
                        ack_err <= data_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 16;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       ack_err;
    logic       timeout_err;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2_clk_line;
    logic       ps2_data_line;

    int n_checks  = 0;
    int n_errors  = 0;
    int done_cnt  = 0;
    int acc_cnt   = 0;
    int inv_viol  = 0;
    int busy_viol = 0;
    bit in_send   = 0;
    bit post_stop = 0;
    bit busy      = 0;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling clk edge; inputs as they stand now are what
    // the intervening rising edge sees, so accepts are counted before waiting.
    task automatic tick();
        if (rst && tx_valid && tx_ready) acc_cnt++;
        @(negedge clk);
        if (done) done_cnt++;
        if (tx_ready && (ps2_clk_oe || ps2_data_oe)) inv_viol++;
        if (in_send && ps2_clk_oe) inv_viol++;
        if (post_stop && ps2_data_oe) inv_viol++;
        if (busy && !done && tx_ready) busy_viol++;
    endtask

    // mode: 0 device ACKs, 1 device withholds ACK, 2 device never clocks,
    //       3 reset pulsed while data bit 4 is on the wire
    task automatic run_xfer(input logic [7:0] d, input bit hold, input int mode);
        logic [10:0] frame;
        logic [10:0] exp_frame;
        int n, nd, k, dc0, ac0, lo, hi, pre, oe_first;
        lo  = $urandom_range(8, 20);
        hi  = $urandom_range(8, 20);
        pre = $urandom_range(5, 60);
        frame = '0;
        exp_frame = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
        check("ready_before", tx_ready, 1);
        dc0 = done_cnt;
        ac0 = acc_cnt;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        if (!hold) tx_valid = 1'b0;
        tx_data = 8'($urandom);
        check("ready_after_accept", tx_ready, 0);
        busy = 1;

        n = 0; nd = 0; oe_first = -1;
        while (ps2_clk_oe && n < 2000) begin
            if (ps2_data_oe) begin
                nd++;
                if (oe_first < 0) oe_first = n;
            end
            n++;
            tick();
        end
        check("clk_oe_cycles", n, INH + 8);
        check("rts_cycles", nd, 8);
        check("rts_start", oe_first, INH);
        in_send = 1;
        check("start_bit_held", ps2_data_oe, 1);

        if (mode == 2) begin
            k = 0;
            while (!done && k < 2000) begin
                k++;
                tick();
            end
            check("timeout_latency", k, TMO);
            check("to_clk_oe", ps2_clk_oe, 0);
            check("to_data_oe", ps2_data_oe, 0);
            check("to_timeout_err", timeout_err, 1);
            check("to_ack_err", ack_err, 0);
            check("to_done_count", done_cnt, dc0 + 1);
            busy = 0;
            in_send = 0;
            return;
        end

        repeat (pre) tick();
        frame[0] = ps2_data_line;
        for (int f = 1; f <= 11; f++) begin
            dev_clk_low = 1'b1;
            repeat (lo) tick();
            if (mode == 3 && f == 5) begin
                #2 rst = 1'b0;
                #1;
                check("rst_clk_oe", ps2_clk_oe, 0);
                check("rst_data_oe", ps2_data_oe, 0);
                check("rst_ready", tx_ready, 1);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                busy = 0;
                in_send = 0;
                tick();
                rst = 1'b1;
                check("rst_ready_after", tx_ready, 1);
                repeat (30) tick();
                check("rst_no_done", done_cnt, dc0);
                return;
            end
            if (f == 11) begin
                check("no_early_done", done_cnt, dc0);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
            end else begin
                dev_clk_low = 1'b0;
                if (f <= 10) frame[f] = ps2_data_line;
                if (f == 10) begin
                    post_stop = 1;
                    repeat (hi / 2) tick();
                    if (mode == 0) dev_data_low = 1'b1;
                    repeat (hi - hi / 2) tick();
                end else begin
                    repeat (hi) tick();
                end
            end
        end

        k = 0;
        while (!done && k < 200) begin
            k++;
            tick();
        end
        check("done_seen", done, 1);
        check("frame", frame, exp_frame);
        check("ack_err", ack_err, (mode == 1) ? 1 : 0);
        check("timeout_err", timeout_err, 0);
        check("accepts", acc_cnt, ac0 + 1);
        busy = 0;
        post_stop = 0;
        in_send = 0;
        if (!hold) begin
            repeat (3) tick();
            check("done_once", done_cnt, dc0 + 1);
        end
    endtask

    initial begin
        int k, ac0;
        rst          = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_clk_oe0", ps2_clk_oe, 0);
        check("rst_data_oe0", ps2_data_oe, 0);
        check("rst_done", done, 0);
        check("rst_errs", {ack_err, timeout_err}, 0);
        rst = 1'b1;
        tick();

        run_xfer(8'hED, 0, 0);
        run_xfer(8'hF4, 0, 0);
        run_xfer(8'h00, 0, 0);
        for (int i = 0; i < 4; i++) run_xfer(8'($urandom), 0, 0);
        run_xfer(8'($urandom), 0, 1);
        run_xfer(8'($urandom), 0, 0);
        run_xfer(8'($urandom), 0, 2);
        run_xfer(8'($urandom), 0, 0);
        run_xfer(8'($urandom), 0, 3);
        run_xfer(8'hFF, 0, 0);

        // tx_valid held high across a whole transfer and into the done cycle
        ac0 = acc_cnt;
        run_xfer(8'($urandom), 1, 0);
        tick();
        tx_valid = 1'b0;
        check("reaccept_count", acc_cnt, ac0 + 2);
        check("reaccept_busy", tx_ready, 0);
        k = 0;
        while (!done && k < 2000) begin
            k++;
            tick();
        end
        check("reaccept_timeout", timeout_err, 1);
        repeat (3) tick();

        check("oe_invariants", inv_viol, 0);
        check("ready_low_while_busy", busy_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
